// File: rtl/ahb_dec_pkg.sv
// Shared AHB-Lite constants and default-slave state encoding for ahb_decoder_mux.
package ahb_dec_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef logic [1:0] ds_state_t;
  localparam ds_state_t DS_IDLE = 2'd0;
  localparam ds_state_t DS_ERR1 = 2'd1;
  localparam ds_state_t DS_ERR2 = 2'd2;
endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: two-cycle AHB ERROR response for unmapped NONSEQ/SEQ transfers.
// Optional ERROR counter enabled by AHB_DECODER_MUX_ERR_CNT_EN.
module ahb_default_slave
  import ahb_dec_pkg::*;
(
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hready,
  input  logic        dflt_sel,
  output logic        hreadyout_d,
  output logic        hresp_d
`ifdef AHB_DECODER_MUX_ERR_CNT_EN
  ,
  output logic [15:0] err_cnt
`endif
);
  ds_state_t state;
  ds_state_t state_next;

  always_comb begin
    state_next = state;
    case (state)
      DS_IDLE: if (hready && dflt_sel) state_next = DS_ERR1;
      DS_ERR1: state_next = DS_ERR2;
      DS_ERR2: state_next = (hready && dflt_sel) ? DS_ERR1 : DS_IDLE;
      default: state_next = DS_IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) state <= DS_IDLE;
    else        state <= state_next;
  end

  assign hreadyout_d = (state != DS_ERR1);
  assign hresp_d     = (state == DS_IDLE) ? HRESP_OKAY : HRESP_ERROR;

`ifdef AHB_DECODER_MUX_ERR_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // One count per completed ERROR response, i.e. per ERR2 cycle
  always_ff @(posedge hclk) begin
    if (hreset)                 err_cnt <= '0;
    else if (state == DS_ERR2)  err_cnt <= sat_inc(err_cnt);
  end
`else
`endif
endmodule

// File: rtl/ahb_decoder_mux.sv
// AHB-Lite address decoder and slave response multiplexer with built-in default slave.
// Optional err_cnt output enabled by AHB_DECODER_MUX_ERR_CNT_EN.
module ahb_decoder_mux
  import ahb_dec_pkg::*;
#(
  parameter int NUM_SLAVES = 3,
  parameter int ADDR_W     = 16,
  parameter int SEL_BITS   = 2,
  parameter int DATA_W     = 32
) (
  input  logic                         hclk,
  input  logic                         hreset,
  input  logic [ADDR_W-1:0]            haddr,
  input  logic [1:0]                   htrans,
  output logic [NUM_SLAVES-1:0]        hsel,
  input  logic [NUM_SLAVES*DATA_W-1:0] hrdata_s,
  input  logic [NUM_SLAVES-1:0]        hreadyout_s,
  input  logic [NUM_SLAVES-1:0]        hresp_s,
  output logic [DATA_W-1:0]            hrdata,
  output logic                         hready,
  output logic                         hresp
`ifdef AHB_DECODER_MUX_ERR_CNT_EN
  ,
  output logic [15:0]                  err_cnt
`endif
);
  logic [SEL_BITS-1:0] region;
  logic                unmapped;
  logic                dflt_sel;
  logic [SEL_BITS-1:0] dsel_idx;
  logic                dsel_dflt;
  logic                hreadyout_d;
  logic                hresp_d;
  logic                unused_addr;

  assign region      = haddr[ADDR_W-1 -: SEL_BITS];
  assign unused_addr = ^haddr[ADDR_W-SEL_BITS-1:0];
  assign unmapped    = int'(region) >= NUM_SLAVES;
  assign dflt_sel    = unmapped && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);

  // Address phase: select depends on haddr only, never on htrans or reset
  always_comb begin
    hsel = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      if (int'(region) == i) hsel[i] = 1'b1;
  end

  // Address -> data phase boundary
  always_ff @(posedge hclk) begin
    if (hreset) begin
      dsel_dflt <= 1'b1;
      dsel_idx  <= '0;
    end else if (hready) begin
      dsel_dflt <= unmapped;
      dsel_idx  <= region;
    end
  end

  // Data phase: response from whichever target owns the current data phase
  always_comb begin
    hrdata = '0;
    hready = hreadyout_d;
    hresp  = hresp_d;
    if (!dsel_dflt) begin
      hready = 1'b1;
      hresp  = HRESP_OKAY;
      for (int i = 0; i < NUM_SLAVES; i++) begin
        if (int'(dsel_idx) == i) begin
          hrdata = hrdata_s[i*DATA_W +: DATA_W];
          hready = hreadyout_s[i];
          hresp  = hresp_s[i];
        end
      end
    end
  end

  ahb_default_slave u_default_slave (
    .hclk        (hclk),
    .hreset      (hreset),
    .hready      (hready),
    .dflt_sel    (dflt_sel),
    .hreadyout_d (hreadyout_d),
    .hresp_d     (hresp_d)
`ifdef AHB_DECODER_MUX_ERR_CNT_EN
    ,
    .err_cnt     (err_cnt)
`endif
  );
endmodule

// File: tb/tb_ahb_decoder_mux.sv
// Self-checking bench for ahb_decoder_mux (default parameters); err_cnt checks under AHB_DECODER_MUX_ERR_CNT_EN.
module tb_ahb_decoder_mux;
  import ahb_dec_pkg::*;

  localparam int NS = 3;
  localparam int AW = 16;
  localparam int SB = 2;
  localparam int DW = 32;

  logic            hclk = 1'b0;
  logic            hreset = 1'b1;
  logic [AW-1:0]   haddr = '0;
  logic [1:0]      htrans = HTRANS_IDLE;
  logic [NS-1:0]   hsel;
  logic [NS*DW-1:0] hrdata_s = '0;
  logic [NS-1:0]   hreadyout_s = '1;
  logic [NS-1:0]   hresp_s = '0;
  logic [DW-1:0]   hrdata;
  logic            hready;
  logic            hresp;
`ifdef AHB_DECODER_MUX_ERR_CNT_EN
  logic [15:0]     err_cnt;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model: owner of the current data phase (-1 = unmapped) and
  // how many ERROR-response cycles remain for it (2 = first, 1 = second).
  int m_target = -1;
  int m_err = 0;
  int m_cnt = 0;

  ahb_decoder_mux #(.NUM_SLAVES(NS), .ADDR_W(AW), .SEL_BITS(SB), .DATA_W(DW)) dut (
    .hclk        (hclk),
    .hreset      (hreset),
    .haddr       (haddr),
    .htrans      (htrans),
    .hsel        (hsel),
    .hrdata_s    (hrdata_s),
    .hreadyout_s (hreadyout_s),
    .hresp_s     (hresp_s),
    .hrdata      (hrdata),
    .hready      (hready),
    .hresp       (hresp)
`ifdef AHB_DECODER_MUX_ERR_CNT_EN
    ,
    .err_cnt     (err_cnt)
`endif
  );

  always #5 hclk = ~hclk;

  function automatic int region_of(input logic [AW-1:0] a);
    return int'(a[AW-1 -: SB]);
  endfunction

  function automatic logic [NS-1:0] exp_hsel(input logic [AW-1:0] a);
    logic [NS-1:0] v;
    int r;
    v = '0;
    r = region_of(a);
    if (r < NS) v[r] = 1'b1;
    return v;
  endfunction

  task automatic model_out(output logic [DW-1:0] d, output logic rd, output logic rs);
    if (m_target >= 0) begin
      d  = hrdata_s[m_target*DW +: DW];
      rd = hreadyout_s[m_target];
      rs = hresp_s[m_target];
    end else begin
      d  = '0;
      rd = (m_err != 2);
      rs = (m_err != 0);
    end
  endtask

  task automatic tick();
    logic [DW-1:0] d;
    logic rd, rs;
    model_out(d, rd, rs);
    @(posedge hclk);
    if (hreset) begin
      m_target = -1;
      m_err = 0;
      m_cnt = 0;
    end else begin
      if (m_target < 0 && m_err == 1 && m_cnt < 65535) m_cnt++;
      if (rd) begin
        m_target = (region_of(haddr) < NS) ? region_of(haddr) : -1;
        m_err = (m_target < 0 && htrans[1]) ? 2 : 0;
      end else if (m_err > 0) begin
        m_err--;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    hreset = 1'b1;
    haddr = 16'h4010;
    htrans = HTRANS_IDLE;
    hrdata_s = {$urandom, $urandom, $urandom};
    @(negedge hclk);
    checks++; if (hsel !== 3'b010) begin failures++; $display("FAIL reset_hsel: got %b expected %b", hsel, 3'b010); end
    tick();
    tick();
    hreset = 1'b0;
    @(negedge hclk);
    checks++; if (hready !== 1'b1) begin failures++; $display("FAIL reset_hready: got %b expected 1", hready); end
    checks++; if (hresp !== 1'b0) begin failures++; $display("FAIL reset_hresp: got %b expected 0", hresp); end
    checks++; if (hrdata !== 32'h0) begin failures++; $display("FAIL reset_hrdata: got %h expected 0", hrdata); end
`ifdef AHB_DECODER_MUX_ERR_CNT_EN
    checks++; if (err_cnt !== 16'h0) begin failures++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
`endif
  endtask

  task automatic test_mapped_read();
    haddr = 16'h4010;
    htrans = HTRANS_NONSEQ;
    hrdata_s = {$urandom, 32'hDEADBEEF, $urandom};
    hreadyout_s = 3'b111;
    hresp_s = 3'b000;
    @(negedge hclk);
    checks++; if (hsel !== 3'b010) begin failures++; $display("FAIL mapped_hsel: got %b expected %b", hsel, 3'b010); end
    tick();
    htrans = HTRANS_IDLE;
    @(negedge hclk);
    checks++; if (hrdata !== 32'hDEADBEEF) begin failures++; $display("FAIL mapped_hrdata: got %h expected deadbeef", hrdata); end
    checks++; if (hresp !== 1'b0) begin failures++; $display("FAIL mapped_hresp: got %b expected 0", hresp); end
    checks++; if (hready !== 1'b1) begin failures++; $display("FAIL mapped_hready: got %b expected 1", hready); end
    tick();
  endtask

  task automatic test_wait_states();
    haddr = 16'h0000;
    htrans = HTRANS_NONSEQ;
    hreadyout_s = 3'b111;
    tick();
    haddr = 16'h8000;
    hreadyout_s[0] = 1'b0;
    hrdata_s[2*DW +: DW] = 32'hCAFE0002;
    for (int k = 0; k < 3; k++) begin
      @(negedge hclk);
      checks++; if (hready !== 1'b0) begin failures++; $display("FAIL ws_stall%0d: hready got %b expected 0", k, hready); end
      checks++; if (hsel !== 3'b100) begin failures++; $display("FAIL ws_hsel%0d: got %b expected %b", k, hsel, 3'b100); end
      tick();
    end
    hreadyout_s[0] = 1'b1;
    @(negedge hclk);
    checks++; if (hready !== 1'b1) begin failures++; $display("FAIL ws_release: hready got %b expected 1", hready); end
    tick();
    hreadyout_s[2] = 1'b0;
    htrans = HTRANS_IDLE;
    @(negedge hclk);
    checks++; if (hready !== 1'b0) begin failures++; $display("FAIL ws_slave2_ready: got %b expected 0", hready); end
    checks++; if (hrdata !== 32'hCAFE0002) begin failures++; $display("FAIL ws_slave2_data: got %h expected cafe0002", hrdata); end
    hreadyout_s[2] = 1'b1;
    tick();
  endtask

  task automatic test_unmapped_nonseq();
    haddr = 16'hC000;
    htrans = HTRANS_NONSEQ;
    @(negedge hclk);
    checks++; if (hsel !== 3'b000) begin failures++; $display("FAIL unm_hsel: got %b expected 000", hsel); end
    tick();
    haddr = 16'h0000;
    htrans = HTRANS_IDLE;
    @(negedge hclk);
    checks++; if ({hready, hresp} !== 2'b01) begin failures++; $display("FAIL unm_err1: ready/resp got %b%b expected 01", hready, hresp); end
    checks++; if (hrdata !== 32'h0) begin failures++; $display("FAIL unm_hrdata: got %h expected 0", hrdata); end
    tick();
    @(negedge hclk);
    checks++; if ({hready, hresp} !== 2'b11) begin failures++; $display("FAIL unm_err2: ready/resp got %b%b expected 11", hready, hresp); end
    tick();
    @(negedge hclk);
    checks++; if ({hready, hresp} !== 2'b10) begin failures++; $display("FAIL unm_done: ready/resp got %b%b expected 10", hready, hresp); end
  endtask

  task automatic test_unmapped_idle_seq();
    haddr = 16'hC000;
    htrans = HTRANS_IDLE;
    tick();
    @(negedge hclk);
    checks++; if ({hready, hresp} !== 2'b10) begin failures++; $display("FAIL idle_unm: ready/resp got %b%b expected 10", hready, hresp); end
    haddr = 16'hC004;
    htrans = HTRANS_SEQ;
    tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge hclk);
      checks++; if ({hready, hresp} !== 2'b01) begin failures++; $display("FAIL b2b_err1_%0d: ready/resp got %b%b expected 01", k, hready, hresp); end
      tick();
      if (k == 2) htrans = HTRANS_IDLE;
      @(negedge hclk);
      checks++; if ({hready, hresp} !== 2'b11) begin failures++; $display("FAIL b2b_err2_%0d: ready/resp got %b%b expected 11", k, hready, hresp); end
      tick();
    end
    @(negedge hclk);
    checks++; if ({hready, hresp} !== 2'b10) begin failures++; $display("FAIL b2b_end: ready/resp got %b%b expected 10", hready, hresp); end
  endtask

  task automatic test_reset_in_err1();
    haddr = 16'hC000;
    htrans = HTRANS_NONSEQ;
    tick();
    htrans = HTRANS_IDLE;
    @(negedge hclk);
    checks++; if (hready !== 1'b0) begin failures++; $display("FAIL rst_err1_ready: got %b expected 0", hready); end
`ifdef AHB_DECODER_MUX_ERR_CNT_EN
    checks++; if (err_cnt !== 16'(m_cnt)) begin failures++; $display("FAIL rst_err1_cnt: got %0d expected %0d", err_cnt, m_cnt); end
`endif
    hreset = 1'b1;
    tick();
    hreset = 1'b0;
    @(negedge hclk);
    checks++; if ({hready, hresp} !== 2'b10) begin failures++; $display("FAIL rst_err1_idle: ready/resp got %b%b expected 10", hready, hresp); end
`ifdef AHB_DECODER_MUX_ERR_CNT_EN
    checks++; if (err_cnt !== 16'h0) begin failures++; $display("FAIL rst_err1_cnt0: got %0d expected 0", err_cnt); end
`endif
    for (int k = 0; k < 3; k++) begin
      htrans = HTRANS_NONSEQ;
      tick();
      htrans = HTRANS_IDLE;
      tick();
      tick();
    end
    @(negedge hclk);
    checks++; if ({hready, hresp} !== 2'b10) begin failures++; $display("FAIL rst_err1_after: ready/resp got %b%b expected 10", hready, hresp); end
`ifdef AHB_DECODER_MUX_ERR_CNT_EN
    checks++; if (err_cnt !== 16'd3) begin failures++; $display("FAIL err_cnt_3: got %0d expected 3", err_cnt); end
`endif
  endtask

  task automatic test_random();
    logic [DW-1:0] d;
    logic rd, rs;
    for (int n = 0; n < 400; n++) begin
      haddr = 16'($urandom);
      htrans = 2'($urandom);
      hrdata_s = {$urandom, $urandom, $urandom};
      for (int i = 0; i < NS; i++) begin
        hreadyout_s[i] = ($urandom_range(0, 3) != 0);
        hresp_s[i] = 1'($urandom);
      end
      hreset = ($urandom_range(0, 49) == 0);
      @(negedge hclk);
      model_out(d, rd, rs);
      checks++; if (hsel !== exp_hsel(haddr)) begin failures++; $display("FAIL rnd_hsel[%0d]: got %b expected %b", n, hsel, exp_hsel(haddr)); end
      checks++; if (hrdata !== d) begin failures++; $display("FAIL rnd_hrdata[%0d]: got %h expected %h", n, hrdata, d); end
      checks++; if (hready !== rd) begin failures++; $display("FAIL rnd_hready[%0d]: got %b expected %b", n, hready, rd); end
      checks++; if (hresp !== rs) begin failures++; $display("FAIL rnd_hresp[%0d]: got %b expected %b", n, hresp, rs); end
`ifdef AHB_DECODER_MUX_ERR_CNT_EN
      checks++; if (err_cnt !== 16'(m_cnt)) begin failures++; $display("FAIL rnd_err_cnt[%0d]: got %0d expected %0d", n, err_cnt, m_cnt); end
`endif
      tick();
    end
    hreset = 1'b0;
    htrans = HTRANS_IDLE;
    hreadyout_s = '1;
    hresp_s = '0;
  endtask

  initial begin
    test_reset();
    test_mapped_read();
    test_wait_states();
    test_unmapped_nonseq();
    test_unmapped_idle_seq();
    test_reset_in_err1();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
